// File: rtl/bcd_convert_ctrl.sv
// Sequential binary-to-BCD converter (shift-and-add-3) with a start/ready/done handshake.
// One correction pass and one left shift per input bit; the result register updates only on entry to DONE.
module bcd_convert_ctrl #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    // state  | meaning
    // IDLE   | waiting for start, ready = 1
    // ADJUST | add 3 to every digit above 4
    // SHIFT  | shift scratch left one bit, count down remaining bits
    // DONE   | one-cycle done pulse, bcd freshly loaded
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ADJUST = 2'd1;
    localparam logic [1:0] S_SHIFT  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam int SW = 4*DIGITS + WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    logic [1:0]          state_q, state_d;
    logic [SW-1:0]       scratch_q, scratch_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic [3:0]          digit;

    always_comb begin
        state_d   = state_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        digit     = 4'd0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    scratch_d = {{(4*DIGITS){1'b0}}, bin};
                    cnt_d     = CW'(WIDTH);
                    state_d   = S_ADJUST;
                end
            end
            S_ADJUST: begin
                for (int i = 0; i < DIGITS; i++) begin
                    digit = scratch_q[WIDTH + 4*i +: 4];
                    if (digit > 4'd4) begin
                        scratch_d[WIDTH + 4*i +: 4] = digit + 4'd3;
                    end
                end
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                scratch_d = {scratch_q[SW-2:0], 1'b0};
                cnt_d     = cnt_q - CW'(1);
                if (cnt_d == '0) begin
                    // capture the digit field of the post-shift value on the edge entering DONE
                    bcd_d   = scratch_d[SW-1 -: 4*DIGITS];
                    state_d = S_DONE;
                end else begin
                    state_d = S_ADJUST;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            scratch_q <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
        end else begin
            state_q   <= state_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
        end
    end

    assign ready = (state_q == S_IDLE);
    assign busy  = (state_q == S_ADJUST) || (state_q == S_SHIFT);
    assign done  = (state_q == S_DONE);
    assign bcd   = bcd_q;

endmodule

// File: tb/tb_bcd_convert_ctrl.sv
// Directed bench for bcd_convert_ctrl: reset, single, busy-request, back-to-back, mid-reset, exhaustive.
// Inputs change and outputs are sampled on the falling edge; cycle k after an accepting edge E is the period following edge E+k-1.
module tb_bcd_convert_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  bin;
    logic        ready;
    logic        busy;
    logic        done;
    logic [11:0] bcd;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;

    bcd_convert_ctrl #(.WIDTH(8), .DIGITS(3)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bin   (bin),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    // Issue one conversion from IDLE; returns the cycle index of done (-1 on timeout) and busy cycle count.
    task automatic run_conv(input logic [7:0] v, output logic [11:0] res, output int lat, output int nbusy);
        lat   = -1;
        nbusy = 0;
        res   = 12'h000;
        bin   = v;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (busy === 1'b1) nbusy++;
            if (done === 1'b1) begin
                lat = k;
                res = bcd;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b0;
        bin   = 8'd0;
        repeat (2) @(negedge clk);
        checks++;
        if ({ready, busy, done} !== 3'b100) begin
            errors++;
            $display("FAIL reset_flags: got rdy/busy/done=%b want 100", {ready, busy, done});
        end
        checks++;
        if (bcd !== 12'h000) begin
            errors++;
            $display("FAIL reset_bcd: got %h want 000", bcd);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single;
        logic [11:0] res;
        int lat, nb, d0;
        d0 = done_cnt;
        run_conv(8'd255, res, lat, nb);
        checks++;
        if (res !== 12'h255) begin
            errors++;
            $display("FAIL single_bcd: got %h want 255", res);
        end
        checks++;
        if (lat !== 17) begin
            errors++;
            $display("FAIL single_latency: got %0d want 17", lat);
        end
        checks++;
        if (nb !== 16) begin
            errors++;
            $display("FAIL single_busy_cycles: got %0d want 16", nb);
        end
        checks++;
        if (ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL single_ready_after: got ready=%b done=%b want 1 0", ready, done);
        end
        checks++;
        if (done_cnt - d0 !== 1) begin
            errors++;
            $display("FAIL single_done_pulses: got %0d want 1", done_cnt - d0);
        end
    endtask

    task automatic test_request_while_busy;
        int d0, seen;
        d0 = done_cnt;
        seen = 0;
        bin = 8'd99;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        bin = 8'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bin = 8'd0;
        for (int k = 0; k < 40 && seen == 0; k++) begin
            if (done === 1'b1) seen = 1;
            else @(negedge clk);
        end
        checks++;
        if (seen == 0 || bcd !== 12'h099) begin
            errors++;
            $display("FAIL busy_req_bcd: got %h (done seen %0d) want 099", bcd, seen);
        end
        repeat (25) @(negedge clk);
        checks++;
        if (done_cnt - d0 !== 1) begin
            errors++;
            $display("FAIL busy_req_done_pulses: got %0d want 1", done_cnt - d0);
        end
        checks++;
        if (ready !== 1'b1 || bcd !== 12'h099) begin
            errors++;
            $display("FAIL busy_req_idle: got ready=%b bcd=%h want 1 099", ready, bcd);
        end
    endtask

    task automatic test_back_to_back;
        int lat1, lat2, held_bad;
        lat1 = -1;
        lat2 = -1;
        held_bad = 0;
        bin = 8'd128;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bin = 8'd7;
        for (int k = 1; k <= 40; k++) begin
            if (done === 1'b1) begin
                lat1 = k;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (lat1 !== 17 || bcd !== 12'h128) begin
            errors++;
            $display("FAIL b2b_first: got lat=%0d bcd=%h want 17 128", lat1, bcd);
        end
        @(negedge clk);
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_idle_gap: got ready=%b want 1", ready);
        end
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second_accept: got busy=%b want 1", busy);
        end
        for (int k = 1; k <= 40; k++) begin
            if (done === 1'b1) begin
                lat2 = k;
                break;
            end
            if (bcd !== 12'h128) held_bad++;
            @(negedge clk);
        end
        checks++;
        if (held_bad != 0) begin
            errors++;
            $display("FAIL b2b_bcd_hold: got %0d cycles not 128 want 0", held_bad);
        end
        checks++;
        if (lat2 !== 17 || bcd !== 12'h007) begin
            errors++;
            $display("FAIL b2b_second: got lat=%0d bcd=%h want 17 007", lat2, bcd);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        logic [11:0] res;
        int lat, nb, d0;
        d0 = done_cnt;
        bin = 8'd200;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({ready, busy, done} !== 3'b100 || bcd !== 12'h000) begin
            errors++;
            $display("FAIL midreset_async: got rdy/busy/done=%b bcd=%h want 100 000", {ready, busy, done}, bcd);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (25) @(negedge clk);
        checks++;
        if (done_cnt - d0 !== 0 || ready !== 1'b1 || bcd !== 12'h000) begin
            errors++;
            $display("FAIL midreset_quiet: got pulses=%0d ready=%b bcd=%h want 0 1 000", done_cnt - d0, ready, bcd);
        end
        run_conv(8'd200, res, lat, nb);
        checks++;
        if (res !== 12'h200 || lat !== 17) begin
            errors++;
            $display("FAIL midreset_rerun: got bcd=%h lat=%0d want 200 17", res, lat);
        end
    endtask

    task automatic test_exhaustive;
        logic [11:0] res, exp;
        int lat, nb;
        for (int v = 0; v < 256; v++) begin
            exp = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
            run_conv(8'(v), res, lat, nb);
            checks++;
            if (res !== exp || lat !== 17) begin
                errors++;
                $display("FAIL exhaustive_%0d: got bcd=%h lat=%0d want %h 17", v, res, lat, exp);
            end
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_request_while_busy;
        test_back_to_back;
        test_reset_mid;
        test_exhaustive;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
